// File: rtl/ysyx_23060042_pkg.sv
// Shared types and constants for the ysyx_23060042 load/store path.
package ysyx_23060042_pkg;

  // Access size as encoded by the decoder (funct3[1:0])
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    ILL  = 2'b11
  } lsu_size_e;

  // LSU transaction states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  localparam logic [3:0] WMASK_ALL = 4'b1111;

endpackage

// File: rtl/ysyx_23060042_lsu_align.sv
// Combinational lane logic: misalign detection, store lane replication and
// byte mask, load extraction and sign/zero extension.
module ysyx_23060042_lsu_align
  import ysyx_23060042_pkg::*;
#(
  parameter int DW = 32
) (
  input  lsu_size_e         size,
  input  logic              is_unsigned,
  input  logic [1:0]        addr_lo,
  input  logic [DW-1:0]     wdata,
  input  logic [DW-1:0]     rdata,
  output logic              misalign,
  output logic [3:0]        wmask,
  output logic [DW-1:0]     wdata_al,
  output logic [DW-1:0]     rdata_ext
);

  logic [DW-1:0] shifted;

  // Misaligned half/word accesses and the reserved size are errors
  always_comb begin
    misalign = 1'b0;
    case (size)
      BYTE:    misalign = 1'b0;
      HALF:    misalign = addr_lo[0];
      WORD:    misalign = (addr_lo != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  // Store data replicated across lanes, mask selects the addressed lanes
  always_comb begin
    wmask    = '0;
    wdata_al = '0;
    case (size)
      BYTE: begin
        wmask    = 4'b0001 << addr_lo;
        wdata_al = {(DW/8){wdata[7:0]}};
      end
      HALF: begin
        wmask    = 4'b0011 << addr_lo;
        wdata_al = {(DW/16){wdata[15:0]}};
      end
      WORD: begin
        wmask    = WMASK_ALL;
        wdata_al = wdata;
      end
      default: begin
        wmask    = '0;
        wdata_al = '0;
      end
    endcase
  end

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Load result: addressed lane moved to bit 0, then extended
  always_comb begin
    rdata_ext = '0;
    case (size)
      BYTE:    rdata_ext = {{(DW-8){shifted[7] & ~is_unsigned}}, shifted[7:0]};
      HALF:    rdata_ext = {{(DW-16){shifted[15] & ~is_unsigned}}, shifted[15:0]};
      WORD:    rdata_ext = shifted;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060042_lsu.sv
// Multi-cycle load/store unit: EXU request handshake, one data memory
// access, write-back response handshake. One transaction outstanding.
module ysyx_23060042_lsu
  import ysyx_23060042_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [3:0]    mem_wmask,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err
);

  lsu_state_e    state, state_nx;

  logic          we_q;
  lsu_size_e     size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;

  logic          idle;
  lsu_size_e     al_size;
  logic          al_uns;
  logic [1:0]    al_addr_lo;
  logic [DW-1:0] al_wdata_in;
  logic          al_misalign;
  logic [3:0]    al_wmask;
  logic [DW-1:0] al_wdata;
  logic [DW-1:0] al_rdata;

  assign idle = (state == IDLE);

  // A single align instance serves both the incoming request (misalign
  // check at accept time) and the latched request (REQ/WAIT datapath).
  assign al_size     = idle ? lsu_size_e'(req_size) : size_q;
  assign al_uns      = idle ? req_unsigned          : uns_q;
  assign al_addr_lo  = idle ? req_addr[1:0]         : addr_q[1:0];
  assign al_wdata_in = idle ? req_wdata             : wdata_q;

  ysyx_23060042_lsu_align #(
    .DW (DW)
  ) u_align (
    .size        (al_size),
    .is_unsigned (al_uns),
    .addr_lo     (al_addr_lo),
    .wdata       (al_wdata_in),
    .rdata       (mem_rdata),
    .misalign    (al_misalign),
    .wmask       (al_wmask),
    .wdata_al    (al_wdata),
    .rdata_ext   (al_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid)     state_nx = al_misalign ? RESP : REQ;
      REQ:  if (mem_req_ready) state_nx = WAIT;
      WAIT: if (mem_rvalid)    state_nx = RESP;
      RESP: if (resp_ready)    state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Request latch and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          size_q  <= lsu_size_e'(req_size);
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          err_q   <= al_misalign;
          rdata_q <= '0;
        end
        WAIT: if (mem_rvalid) begin
          rdata_q <= we_q ? '0 : al_rdata;
        end
        default: ;
      endcase
    end
  end

  // Outputs are driven only in their owning state so idle ports read zero
  always_comb begin
    req_ready     = (state == IDLE);
    mem_req_valid = (state == REQ);
    mem_addr      = '0;
    mem_wen       = 1'b0;
    mem_wmask     = '0;
    mem_wdata     = '0;
    resp_valid    = (state == RESP);
    resp_rdata    = '0;
    resp_err      = 1'b0;
    if (state == REQ) begin
      mem_addr = {addr_q[AW-1:2], 2'b00};
      if (we_q) begin
        mem_wen   = 1'b1;
        mem_wmask = al_wmask;
        mem_wdata = al_wdata;
      end
    end
    if (state == RESP) begin
      resp_rdata = rdata_q;
      resp_err   = err_q;
    end
  end

endmodule

// File: tb/tb_ysyx_23060042_lsu.sv
// Self-checking bench for ysyx_23060042_lsu with a behavioural reference model.
module tb_ysyx_23060042_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int errors = 0;
  int checks = 0;

  ysyx_23060042_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: expected error, store mask/data and response data
  function automatic void model(input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic err, output logic [3:0] mask,
                                output logic [31:0] mwd, output logic [31:0] rdat);
    int unsigned k;
    logic [31:0] v;
    k = addr % 4;
    err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
          (size == 2'd2 && k != 0);
    mask = 4'd0; mwd = 32'd0; rdat = 32'd0; v = 32'd0;
    if (err) return;
    if (size == 2'd0) begin
      mask = 4'(1 << k);
      mwd  = (wd & 32'hFF) * 32'h01010101;
      v    = (rd >> (8 * k)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      mask = 4'(3 << k);
      mwd  = (wd & 32'hFFFF) * 32'h00010001;
      v    = (rd >> (8 * k)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      mask = 4'hF;
      mwd  = wd;
      v    = rd;
    end
    if (we) rdat = 32'd0;
    else begin rdat = v; mask = 4'd0; end
  endfunction

  // One full transaction with configurable memory/write-back stalls
  task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int unsigned req_stall,
                        input int unsigned rv_delay, input int unsigned resp_stall,
                        input string tag);
    logic        e_err;
    logic [3:0]  e_mask;
    logic [31:0] e_wd, e_rd;
    model(we, size, uns, addr, wd, rd, e_err, e_mask, e_wd, e_rd);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_req_ready got=%b exp=1", tag, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom);
    req_unsigned = $urandom; req_addr = $urandom; req_wdata = $urandom;
    if (!e_err) begin
      for (int unsigned i = 0; i <= req_stall; i++) begin
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== (addr & 32'hFFFFFFFC) ||
            mem_wen !== we || mem_wmask !== e_mask || req_ready !== 1'b0 ||
            resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s mem_req got v=%b a=%h wen=%b m=%b rr=%b rv=%b exp v=1 a=%h wen=%b m=%b rr=0 rv=0",
                   tag, mem_req_valid, mem_addr, mem_wen, mem_wmask, req_ready,
                   resp_valid, addr & 32'hFFFFFFFC, we, e_mask);
        end
        if (we) begin
          checks++;
          if (mem_wdata !== e_wd) begin
            errors++; $display("FAIL %s mem_wdata got=%h exp=%h", tag, mem_wdata, e_wd);
          end
        end
        mem_req_ready = (i == req_stall);
        mem_rvalid = (i < req_stall) ? 1'($urandom) : 1'b0;
        mem_rdata = $urandom;
        tick();
      end
      mem_req_ready = 1'b0;
      for (int unsigned i = 0; i < rv_delay; i++) begin
        checks++;
        if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
          errors++; $display("FAIL %s wait got rv=%b mv=%b exp 0 0", tag, resp_valid, mem_req_valid);
        end
        tick();
      end
      mem_rvalid = 1'b1; mem_rdata = rd;
      tick();
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end else begin
      checks++;
      if (mem_req_valid !== 1'b0) begin
        errors++; $display("FAIL %s err_no_mem got=%b exp=0", tag, mem_req_valid);
      end
    end
    for (int unsigned i = 0; i <= resp_stall; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== e_rd || resp_err !== e_err ||
          req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s resp got v=%b d=%h e=%b rr=%b mv=%b exp v=1 d=%h e=%b rr=0 mv=0",
                 tag, resp_valid, resp_rdata, resp_err, req_ready, mem_req_valid, e_rd, e_err);
      end
      resp_ready = (i == resp_stall);
      // a request offered during the handshake cycle must not be taken
      if (i == resp_stall) begin
        req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h8000_0100;
      end
      tick();
    end
    resp_ready = 1'b0; req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL %s back_to_idle got rv=%b rr=%b mv=%b exp 0 1 0",
                         tag, resp_valid, req_ready, mem_req_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; mem_req_ready = 0; mem_rvalid = 0;
    mem_rdata = 0; resp_ready = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_addr !== 32'd0 ||
        mem_wen !== 1'b0 || mem_wmask !== 4'd0 || mem_wdata !== 32'd0 ||
        resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset got rr=%b mv=%b a=%h wen=%b m=%b wd=%h rv=%b d=%h e=%b exp rr=1 rest 0",
               req_ready, mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
               resp_valid, resp_rdata, resp_err);
    end
  endtask

  task automatic test_store_byte();
    do_txn(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h1234_56AB, 32'h0, 0, 0, 0, "sb");
  endtask

  task automatic test_load_byte();
    do_txn(1'b0, 2'd0, 1'b0, 32'h8000_0002, 32'h0, 32'h1280_FF00, 0, 0, 0, "lb");
    do_txn(1'b0, 2'd0, 1'b1, 32'h8000_0002, 32'h0, 32'h1280_FF00, 0, 1, 0, "lbu");
  endtask

  task automatic test_misaligned();
    do_txn(1'b0, 2'd1, 1'b0, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0, "lh_mis");
    do_txn(1'b1, 2'd2, 1'b0, 32'h8000_0002, 32'hFFFF_FFFF, 32'h0, 0, 0, 1, "sw_mis");
    do_txn(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, "ill_size");
  endtask

  task automatic test_req_stall();
    do_txn(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 3, 0, 0, "lw_stall");
  endtask

  task automatic test_resp_stall();
    do_txn(1'b0, 2'd1, 1'b0, 32'h8000_0006, 32'h0, 32'h8001_0000, 0, 0, 2, "lh_rstall");
  endtask

  task automatic test_reset_in_wait();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0020;
    tick();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_addr !== 32'd0 ||
        resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 ||
        mem_wen !== 1'b0 || mem_wmask !== 4'd0 || mem_wdata !== 32'd0) begin
      errors++; $display("FAIL rst_in_wait got rr=%b mv=%b a=%h rv=%b d=%h exp rr=1 rest 0",
                         req_ready, mem_req_valid, mem_addr, resp_valid, resp_rdata);
    end
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL spurious_rvalid got rv=%b rr=%b exp 0 1", resp_valid, req_ready);
      end
      tick();
    end
    do_txn(1'b0, 2'd2, 1'b0, 32'h8000_0024, 32'h0, 32'h1357_9BDF, 1, 0, 0, "post_rst_lw");
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 2'd1, 1'b0, 32'h8000_0042, 32'hAAAA_5A5A, 32'h0, 0, 0, 0, "b2b_sh");
    do_txn(1'b0, 2'd1, 1'b1, 32'h8000_0042, 32'h0, 32'hF00F_0000, 0, 0, 0, "b2b_lhu");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_byte();
    test_misaligned();
    test_req_stall();
    test_resp_stall();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_23060042_lsu.md
# ysyx_23060042_lsu

Multi-cycle load/store unit between the execute stage and data memory. It takes one memory request per transaction from EXU over a valid/ready handshake and issues a word-aligned, byte-masked access to the data memory port. It waits for the memory response, then returns sign- or zero-extended load data (or a store acknowledge) to write-back over a second valid/ready handshake. It replaces the single-cycle combinational memory path and is the first step toward a bus-based core.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (fixed 32; other values are unsupported)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  EXU request valid
- `req_ready`  out  1  LSU can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  load zero-extends when 1 (LBU/LHU)
- `req_addr`  in  AW  byte address (rdata1 + imm)
- `req_wdata`  in  DW  store data (rdata2)
- `mem_req_valid`  out  1  memory request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`  out  AW  word address: {req_addr[AW-1:2], 2'b00}
- `mem_wen`  out  1  write enable
- `mem_wmask`  out  4  byte write mask
- `mem_wdata`  out  DW  lane-replicated store data
- `mem_rvalid`  in  1  memory response (load data or write ack)
- `mem_rdata`  in  DW  memory read word
- `resp_valid`  out  1  result valid to write-back
- `resp_ready`  in  1  write-back accepts result
- `resp_rdata`  out  DW  extended load data; 0 for stores
- `resp_err`  out  1  misaligned or illegal-size request

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch all request fields.
  - Misaligned or illegal request → RESP with err=1. Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - Otherwise → REQ.
- REQ: `mem_req_valid`=1. All mem_* outputs stay stable until `mem_req_ready`, then → WAIT.
- WAIT: on `mem_rvalid`, capture the extracted load result and → RESP. `mem_rvalid` is ignored in every state other than WAIT.
- RESP: `resp_valid`=1 with stable `resp_rdata`/`resp_err` until `resp_ready`, then → IDLE.
- Store alignment:
  - byte: wdata={4{wdata[7:0]}}, wmask=4'b0001<<addr[1:0]
  - half: wdata={2{wdata[15:0]}}, wmask=4'b0011<<addr[1:0]
  - word: wdata=wdata, wmask=4'b1111
- Load: `mem_wen`=0 and `mem_wmask`=0. Extract the word as rdata>>(8*addr[1:0]), keep the low 8 or 16 bits, then sign- or zero-extend per `req_unsigned`.
- Error responses never assert `mem_req_valid` and return `resp_rdata`=0.

## Timing
- Reset value of all outputs: 0, except `req_ready`=1 (state IDLE). Reset also clears the latched request and result registers.
- Best-case aligned latency: accept at cycle 0, `mem_req_valid` at cycle 1, `mem_rvalid` no earlier than cycle 2, `resp_valid` in the cycle after `mem_rvalid`.
- Error latency: `resp_valid` at cycle 1.
- One outstanding transaction. `req_ready`=0 in REQ, WAIT and RESP. No request is accepted in the same cycle as a `resp_ready` handshake.
- Reset during REQ or WAIT aborts the transaction. A `mem_rvalid` arriving after reset is ignored.

## Structure
- Shared package `ysyx_23060042_pkg` holds:
  - `lsu_size_e` (BYTE, HALF, WORD, ILL)
  - `lsu_state_e`
  - constant `WMASK_ALL`=4'b1111
- Sub-module `ysyx_23060042_lsu_align` is purely combinational. It computes the misalign flag, store mask and data, and load extraction/extension. The FSM and registers stay in the top module.

## Test plan
- `sb` addr 0x80000003, wdata 0x123456AB → mem_addr 0x80000000, wmask 4'b1000, mem_wdata 0xABABABAB, mem_wen=1; resp_rdata=0, err=0.
- `lb` addr 0x80000002, mem_rdata 0x1280FF00 → resp_rdata 0xFFFFFF80. Repeat with req_unsigned=1 → 0x00000080.
- `lh` addr 0x80000001 → resp_valid at cycle 1, resp_err=1, mem_req_valid never asserted.
- `lw` addr 0x80000010 with mem_req_ready low 3 cycles → mem_req_valid/mem_addr held 0x80000010 for 4 cycles. mem_rdata 0xDEADBEEF → resp_rdata 0xDEADBEEF.
- resp_ready low 2 cycles → resp_valid and resp_rdata stable, req_ready=0 throughout.
- `rst` pulse in WAIT, then a spurious mem_rvalid → all outputs at reset values, resp_valid stays 0, next request is processed normally.
